// File: rtl/conv_window_5x5.sv
// ============================================================================
//  Module      : conv_window_5x5
//  Description : Builds a 5x5 pixel neighbourhood from a raster pixel stream
//                using four line memories and a 5x5 register window.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_window_5x5 #(
    parameter int D     = 16,
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  wire logic              i_clk,
    input  wire logic              i_rst,
    input  wire logic              i_valid,
    input  wire logic              i_sof,
    input  wire logic [D-1:0]      i_data,
    output logic                   o_valid,
    output logic                   o_eof,
    output logic [25*D-1:0]        o_window
);

    localparam int c_CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(IMG_W - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IMG_H - 1);
    localparam logic [c_CW-1:0] c_COL_FIRST_FULL = c_CW'(4);
    localparam logic [c_RW-1:0] c_ROW_FIRST_FULL = c_RW'(4);

    logic [c_CW-1:0] r_col;
    logic [c_RW-1:0] r_row;
    logic            r_valid;
    logic            r_eof;
    logic [D-1:0]    r_lb  [0:3][0:IMG_W-1];
    logic [D-1:0]    r_win [0:4][0:4];

    logic [c_CW-1:0] w_col;
    logic [c_RW-1:0] w_row;
    logic [c_CW-1:0] w_col_next;
    logic [c_RW-1:0] w_row_next;
    logic [D-1:0]    w_lb [0:3];
    logic            w_full;
    logic            w_last;

    // A start-of-frame pixel overrides whatever position the counters hold.
    always_comb begin
        w_col  = i_sof ? '0 : r_col;
        w_row  = i_sof ? '0 : r_row;
        w_full = (w_row >= c_ROW_FIRST_FULL) && (w_col >= c_COL_FIRST_FULL);
        w_last = (w_row == c_ROW_LAST) && (w_col == c_COL_LAST);
        for (int k = 0; k < 4; k++) begin
            w_lb[k] = r_lb[k][w_col];
        end
        if (w_col == c_COL_LAST) begin
            w_col_next = '0;
            w_row_next = (w_row == c_ROW_LAST) ? '0 : w_row + 1'b1;
        end else begin
            w_col_next = w_col + 1'b1;
            w_row_next = w_row;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_col   <= '0;
            r_row   <= '0;
            r_valid <= 1'b0;
            r_eof   <= 1'b0;
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else begin
            r_valid <= i_valid && w_full;
            r_eof   <= i_valid && w_last;
            if (i_valid) begin
                r_col <= w_col_next;
                r_row <= w_row_next;
                for (int r = 0; r < 5; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        r_win[r][c] <= r_win[r][c+1];
                    end
                end
                r_win[0][4] <= w_lb[3];
                r_win[1][4] <= w_lb[2];
                r_win[2][4] <= w_lb[1];
                r_win[3][4] <= w_lb[0];
                r_win[4][4] <= i_data;
            end
        end
    end

    // Line memories carry no reset; each row slides one memory deeper per pass.
    always_ff @(posedge i_clk) begin
        if (!i_rst && i_valid) begin
            r_lb[0][w_col] <= i_data;
            r_lb[1][w_col] <= w_lb[0];
            r_lb[2][w_col] <= w_lb[1];
            r_lb[3][w_col] <= w_lb[2];
        end
    end

    assign o_valid = r_valid;
    assign o_eof   = r_eof;

    for (genvar gr = 0; gr < 5; gr++) begin : g_row
        for (genvar gc = 0; gc < 5; gc++) begin : g_col
            assign o_window[(gr*5+gc)*D +: D] = r_win[gr][gc];
        end
    end

endmodule

`default_nettype wire

// File: doc/conv_window_5x5.md
Name: conv_window_5x5

Overview:
- Upstream stage of the 5x5 convolution datapath.
- Accepts a raster-order pixel stream, one pixel per cycle with gaps allowed, and builds the full 5x5 neighbourhood around each pixel position.
- Buffers the four previous image rows in line memories and holds a 5x5 register window.
- Presents all 25 taps in parallel, with a valid flag, to the d_ff pipeline and MAC stage that follow it.

Parameters:
- D, 16, pixel data width in bits
- IMG_W, 32, pixels per image row (>= 5)
- IMG_H, 32, rows per frame (>= 5)

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous reset, active high
- i_valid  in  1  pixel strobe; pixel is accepted on any edge where it is high
- i_sof  in  1  start of frame; sampled only with i_valid; marks the accepted pixel as (row 0, col 0)
- i_data  in  D  pixel value
- o_valid  out  1  o_window holds a complete 5x5 neighbourhood
- o_eof  out  1  with o_valid, this is the last window of the frame
- o_window  out  25*D  taps; tap k = r*5+c at o_window[k*D +: D]; r=0 is the oldest row, c=0 the oldest column; tap 24 is the newest pixel

Behaviour:
- Reset (i_rst=1 at an edge):
  - col and row counters go to 0.
  - o_valid, o_eof and all 25 window registers go to 0.
  - Line memory contents are not cleared and are don't-care.
- Counters: col in 0..IMG_W-1, row in 0..IMG_H-1. They give the position of the next pixel to be accepted.
  - On an accepted pixel, col increments.
  - At IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0, so the next frame needs no i_sof.
- i_sof with i_valid: the accepted pixel is treated as (0,0) whatever the counter values; the counters then advance to (0,1).
- Line memories: four IMG_W x D memories LB0..LB3, addressed by col. LB0 holds the previous row, LB3 the oldest.
  - On an accepted pixel, read-before-write at address col.
  - Write: LB0 takes i_data, LB1 takes the old LB0, LB2 takes the old LB1, LB3 takes the old LB2.
- Window update on an accepted pixel:
  - Each window row shifts one column toward c=0.
  - Column c=4 loads the new column: r=0 from LB3, r=1 from LB2, r=2 from LB1, r=3 from LB0, r=4 from i_data.
  - The window holds when i_valid is low.
- o_valid:
  - Registered; high the cycle after an accepted pixel at position (row>=4, col>=4).
  - Low the cycle after any other accepted pixel, and low on every cycle with no accepted pixel.
  - Latency is exactly 1 cycle from pixel to window.
- o_eof: registered; high only together with o_valid for pixel (IMG_H-1, IMG_W-1).
- Row boundary: windows whose newest pixel is at col 0..3 straddle two rows. o_valid is 0 for them, so stale columns never reach the output.
- Simultaneous i_rst and i_valid: reset wins and the pixel is discarded.
- Reset mid-frame: the next accepted pixel is (0,0). No o_valid is raised until 4 rows and 5 columns have been refilled.
- i_sof mid-frame: same restart behaviour as reset, except the sof pixel itself is stored as (0,0).
- Valid windows per frame: (IMG_H-4)*(IMG_W-4).

Test Plan (D=16, IMG_W=8, IMG_H=8; stimulus pixel = row*16+col, i_sof on (0,0)):
- Hold i_rst=1 for 3 cycles while driving i_valid=1 -> o_valid=0, o_eof=0, o_window=0 throughout; counters at (0,0) after release.
- Contiguous frame of 64 pixels ->
  - first o_valid on the cycle after pixel 36 (0x44) is accepted, with tap0=0x00, tap12=0x22, tap24=0x44;
  - exactly 16 o_valid pulses in total.
- Row wrap -> pixels (5,0)..(5,3) give o_valid=0; pixel (5,4) gives o_valid=1 with tap0=0x10, tap4=0x14, tap24=0x54.
- Same frame with i_valid low every other cycle -> the same 16 windows in the same order; each o_valid follows its accepting edge by 1 cycle; the window holds during gaps.
- End of frame -> the last window has tap24=0x77, tap0=0x33 and o_eof=1. A second frame sent without i_sof -> first o_valid again at its pixel (4,4); o_eof never seen otherwise.
- Pulse i_rst at pixel (5,2), then resume from (0,0) with i_sof -> no o_valid until the new pixel (4,4); first window tap24=0x44, with no taps from the aborted frame.
